// File: rtl/xnor_parity_frame_pkg.sv
// Shared definitions for the streaming parity frame checker:
// FSM state encoding, reduction mode constants and the length-width helper.
package parity_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Reduction modes: even parity is the XNOR of all bits, odd parity the XOR.
    localparam int PAR_EVEN_XNOR = 0;
    localparam int PAR_ODD_XOR   = 1;

    // Bits needed to hold a word count in the range 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/xnor_parity_frame_if.sv
// Word-in / result-out handshake bundle for xnor_parity_frame.
// master = word source plus result consumer, slave = the parity block.
interface xnor_parity_frame_if
    import parity_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_LEN = 16
);
    localparam int LEN_W = len_width(MAX_LEN);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_par;

    logic             out_valid;
    logic             out_ready;
    logic             out_par;
    logic             out_match;
    logic [LEN_W-1:0] out_len;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, in_par, out_ready,
        input  in_ready, out_valid, out_par, out_match, out_len, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, in_par, out_ready,
        output in_ready, out_valid, out_par, out_match, out_len, out_ovf
    );

endinterface

// File: rtl/xnor_parity_frame_reduce.sv
// Combinational XOR/XNOR reduction of one word. MODE selects the
// polarity: PAR_ODD_XOR gives plain XOR, PAR_EVEN_XNOR its complement.
module xnor_reduce
    import parity_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MODE  = PAR_EVEN_XNOR
) (
    input  logic [WIDTH-1:0] i_word,
    output logic             o_par
);

    // Running XOR through the word, bit 0 first.
    logic [WIDTH:0] w_chain;

    assign w_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            assign w_chain[gi+1] = w_chain[gi] ^ i_word[gi];
        end
    endgenerate

    assign o_par = (MODE == PAR_ODD_XOR) ? w_chain[WIDTH] : ~w_chain[WIDTH];

endmodule

// File: rtl/xnor_parity_frame.sv
// Streaming frame parity checker: folds every accepted word into one
// parity bit, compares it with the expected parity given on the last word,
// and holds the result (parity, match, length, overflow) until it is taken.
// Optional build macro PARITY_ERR_CNT_EN adds a saturating count of
// mismatching frames on err_cnt; without it err_cnt is constant zero.
module xnor_parity_frame
    import parity_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_LEN = 16,
    parameter int ODD     = PAR_EVEN_XNOR
) (
    input  logic                 clk,
    input  logic                 rst,
    xnor_parity_frame_if.slave   bus,
    output logic [15:0]          err_cnt
);

    localparam int               LEN_W   = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_beat;
    logic             w_xfer;

    logic             r_acc;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic             w_at_max;
    logic [LEN_W-1:0] w_len_sat;
    logic             w_ovf_sat;

    logic             w_word_xor;
    logic             w_frame_par;

    logic             r_out_par;
    logic             r_out_match;
    logic [LEN_W-1:0] r_out_len;
    logic             r_out_ovf;

    // Per-word XOR; polarity is applied only once, on the whole frame.
    xnor_reduce #(
        .WIDTH (WIDTH),
        .MODE  (PAR_ODD_XOR)
    ) u_word_reduce (
        .i_word (bus.in_data),
        .o_par  (w_word_xor)
    );

    // Frame parity = accumulated XOR combined with the last word, in the configured polarity.
    xnor_reduce #(
        .WIDTH (2),
        .MODE  (ODD)
    ) u_frame_reduce (
        .i_word ({r_acc, w_word_xor}),
        .o_par  (w_frame_par)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake decodes; ready/valid depend on the state only.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ACCUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = ACCUM;
                end
            end
            default: begin
                w_state_next = ACCUM;
            end
        endcase
    end

    assign w_beat = bus.in_valid & w_in_ready;
    assign w_xfer = w_out_valid & bus.out_ready;

    // Length saturates at MAX_LEN; any beat arriving at the cap flags overflow.
    assign w_at_max  = (r_len == LEN_MAX);
    assign w_len_sat = w_at_max ? LEN_MAX : (r_len + LEN_W'(1));
    assign w_ovf_sat = r_ovf | w_at_max;

    // Running frame state: accumulate on beats, clear once the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 1'b0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_acc <= 1'b0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= r_acc ^ w_word_xor;
            r_len <= w_len_sat;
            r_ovf <= w_ovf_sat;
        end
    end

    // Result registers: captured on the last-word beat, stable through HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_par   <= 1'b0;
            r_out_match <= 1'b0;
            r_out_len   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_beat && bus.in_last) begin
            r_out_par   <= w_frame_par;
            r_out_match <= (w_frame_par == bus.in_par);
            r_out_len   <= w_len_sat;
            r_out_ovf   <= w_ovf_sat;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_par   = r_out_par;
    assign bus.out_match = r_out_match;
    assign bus.out_len   = r_out_len;
    assign bus.out_ovf   = r_out_ovf;

`ifdef PARITY_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Count mismatching frames as they are handed over; stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 16'd0;
        end else if (w_xfer && !r_out_match && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'd0;
`endif

endmodule
